// File: rtl/seg7_capture_if.sv
// Bundle of pin-side inputs and decoded outputs for seg7_capture.
// update is a single-cycle strobe with no back-pressure: a consumer must sample value/digit_valid in that cycle.
interface seg7_capture_if #(
    parameter int DIGITS = 4
);
    logic [6:0]          abcdefg_in;
    logic [DIGITS-1:0]   digit_in;
    logic                clear_error;
    logic [4*DIGITS-1:0] value;
    logic [DIGITS-1:0]   digit_valid;
    logic                update;
    logic                bad_pattern;

    modport master (
        output abcdefg_in, digit_in, clear_error,
        input  value, digit_valid, update, bad_pattern
    );

    modport slave (
        input  abcdefg_in, digit_in, clear_error,
        output value, digit_valid, update, bad_pattern
    );
endinterface

// File: rtl/seg7_capture.sv
// Samples a multiplexed 7-segment display from pins, waits for a stable pattern,
// and decodes it back to a hex nibble per digit position.
module seg7_capture #(
    parameter int DIGITS        = 4,
    parameter int STABLE_CYCLES = 16
) (
    input  logic          clk,
    input  logic          reset,
    seg7_capture_if.slave bus
);
    localparam int W  = DIGITS + 7;
    localparam int CW = $clog2(STABLE_CYCLES + 1);

    logic [W-1:0]        sync1, s, s_prev;
    logic [CW-1:0]       cnt;
    logic [4*DIGITS-1:0] value_r;
    logic [DIGITS-1:0]   valid_r;
    logic                update_r;
    logic                bad_r;

    logic [DIGITS-1:0]   sel;
    logic [6:0]          pat;
    logic                sel_onehot;
    logic                capture;
    logic [4:0]          dec;

    // Returns {known, nibble}; unknown patterns decode to 0.
    function automatic logic [4:0] decode(input logic [6:0] p);
        case (p)
            7'b1111110: decode = {1'b1, 4'h0};
            7'b0110000: decode = {1'b1, 4'h1};
            7'b1101101: decode = {1'b1, 4'h2};
            7'b1111001: decode = {1'b1, 4'h3};
            7'b0110011: decode = {1'b1, 4'h4};
            7'b1011011: decode = {1'b1, 4'h5};
            7'b1011111: decode = {1'b1, 4'h6};
            7'b1110000: decode = {1'b1, 4'h7};
            7'b1111111: decode = {1'b1, 4'h8};
            7'b1111011: decode = {1'b1, 4'h9};
            7'b1110111: decode = {1'b1, 4'hA};
            7'b0011111: decode = {1'b1, 4'hB};
            7'b1001110: decode = {1'b1, 4'hC};
            7'b0111101: decode = {1'b1, 4'hD};
            7'b1001111: decode = {1'b1, 4'hE};
            7'b1000111: decode = {1'b1, 4'hF};
            default:    decode = 5'b0;
        endcase
    endfunction

    always_comb begin
        sel        = s[W-1:7];
        pat        = s[6:0];
        sel_onehot = (sel != '0) && ((sel & (sel - DIGITS'(1))) == '0);
        // cnt saturates at STABLE_CYCLES, so this fires once per stable period.
        capture    = (s == s_prev) && (cnt == CW'(STABLE_CYCLES - 1));
        dec        = decode(pat);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1    <= '0;
            s        <= '0;
            s_prev   <= '0;
            cnt      <= '0;
            value_r  <= '0;
            valid_r  <= '0;
            update_r <= 1'b0;
            bad_r    <= 1'b0;
        end else begin
            sync1    <= {bus.digit_in, bus.abcdefg_in};
            s        <= sync1;
            s_prev   <= s;
            update_r <= 1'b0;

            if (s != s_prev)
                cnt <= '0;
            else if (cnt != CW'(STABLE_CYCLES))
                cnt <= cnt + CW'(1);

            if (bus.clear_error)
                bad_r <= 1'b0;

            // A zero or multi-hot select is a blanking interval and is ignored.
            if (capture && sel_onehot) begin
                for (int i = 0; i < DIGITS; i++) begin
                    if (sel[i]) begin
                        if (dec[4]) begin
                            value_r[4*i +: 4] <= dec[3:0];
                            valid_r[i]        <= 1'b1;
                            update_r          <= 1'b1;
                        end else if (pat == 7'b0) begin
                            valid_r[i] <= 1'b0;
                        end else begin
                            valid_r[i] <= 1'b0;
                            bad_r      <= 1'b1;
                        end
                    end
                end
            end
        end
    end

    assign bus.value       = value_r;
    assign bus.digit_valid = valid_r;
    assign bus.update      = update_r;
    assign bus.bad_pattern = bad_r;
endmodule

// File: tb/tb_seg7_capture.sv
// Directed bench for seg7_capture: expected nibble words are queued at stimulus time
// and compared against value whenever update pulses.
module tb_seg7_capture;
    localparam int DIGITS = 4;
    localparam int STABLE = 16;
    localparam int LAT    = STABLE + 3;

    logic clk = 1'b0;
    logic reset = 1'b1;

    seg7_capture_if #(.DIGITS(DIGITS)) bus ();

    seg7_capture #(.DIGITS(DIGITS), .STABLE_CYCLES(STABLE)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int n_upd    = 0;
    logic [4*DIGITS-1:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
            $error("check %s differs", tag);
        end
    endtask

    // Scoreboard side: every update must match the next queued value word.
    always @(negedge clk) begin
        if (!reset && bus.update === 1'b1) begin
            n_upd++;
            if (exp_q.size() == 0)
                check("unexpected_update", 32'd1, 32'd0);
            else
                check("sb_value", 32'(bus.value), 32'(exp_q.pop_front()));
        end
    end

    task automatic wait_edges(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [DIGITS-1:0] d, input logic [6:0] p);
        bus.digit_in   = d;
        bus.abcdefg_in = p;
    endtask

    // Holds inputs for n edges and reports the edge number of the first update (0 = none).
    task automatic hold(input int n, output int lat);
        lat = 0;
        for (int k = 1; k <= n; k++) begin
            @(posedge clk);
            #1;
            if (bus.update === 1'b1 && lat == 0) lat = k;
        end
    endtask

    initial begin
        int lat;
        int upd0;
        bus.digit_in    = '0;
        bus.abcdefg_in  = '0;
        bus.clear_error = 1'b0;

        // Reset and idle
        wait_edges(2);
        check("reset_value", 32'(bus.value), 32'h0);
        check("reset_valid", 32'(bus.digit_valid), 32'h0);
        check("reset_bad", 32'(bus.bad_pattern), 32'h0);
        reset = 1'b0;
        hold(50, lat);
        check("idle_no_update", 32'(lat), 32'd0);
        check("idle_value", 32'(bus.value), 32'h0);
        check("idle_bad", 32'(bus.bad_pattern), 32'h0);

        // Single digit, latency
        drive(4'b0001, 7'b1111001);
        exp_q.push_back(16'h0003);
        upd0 = n_upd;
        hold(30, lat);
        check("latency", 32'(lat), 32'(LAT));
        check("single_value", 32'(bus.value), 32'h0003);
        check("single_valid", 32'(bus.digit_valid), 32'b0001);
        check("single_pulses", 32'(n_upd - upd0), 32'd1);

        // Rotate 0, C, 5, A across the four digits
        upd0 = n_upd;
        drive(4'b0001, 7'b1111110); exp_q.push_back(16'h0000); hold(40, lat);
        drive(4'b0000, 7'b0000000); wait_edges(5);
        drive(4'b0010, 7'b1001110); exp_q.push_back(16'h00C0); hold(40, lat);
        drive(4'b0000, 7'b0000000); wait_edges(5);
        drive(4'b0100, 7'b1011011); exp_q.push_back(16'h05C0); hold(40, lat);
        drive(4'b0000, 7'b0000000); wait_edges(5);
        drive(4'b1000, 7'b1110111); exp_q.push_back(16'hA5C0); hold(40, lat);
        drive(4'b0000, 7'b0000000); wait_edges(5);
        check("rot_value", 32'(bus.value), 32'hA5C0);
        check("rot_valid", 32'(bus.digit_valid), 32'b1111);
        check("rot_pulses", 32'(n_upd - upd0), 32'd4);

        // Short glitch is ignored
        upd0 = n_upd;
        drive(4'b0100, 7'b1111111); wait_edges(10);
        drive(4'b0000, 7'b0000000); wait_edges(30);
        check("glitch_value", 32'(bus.value), 32'hA5C0);
        check("glitch_pulses", 32'(n_upd - upd0), 32'd0);

        // Valid then invalid pattern on digit 1
        drive(4'b0010, 7'b1111111); exp_q.push_back(16'hA580); hold(30, lat);
        check("d1_eight", 32'(bus.value[7:4]), 32'h8);
        upd0 = n_upd;
        drive(4'b0010, 7'b1010101); hold(30, lat);
        check("bad_set", 32'(bus.bad_pattern), 32'd1);
        check("bad_valid", 32'(bus.digit_valid), 32'b1101);
        check("bad_value", 32'(bus.value), 32'hA580);
        check("bad_no_update", 32'(n_upd - upd0), 32'd0);

        // clear_error coinciding with a fresh error capture
        drive(4'b0000, 7'b0000000); wait_edges(5);
        drive(4'b0010, 7'b1010101);
        wait_edges(LAT - 1);
        bus.clear_error = 1'b1;
        wait_edges(1);
        bus.clear_error = 1'b0;
        check("set_wins", 32'(bus.bad_pattern), 32'd1);
        wait_edges(11);

        // Fix the pattern, error stays sticky until cleared
        drive(4'b0010, 7'b1111111); exp_q.push_back(16'hA580); hold(30, lat);
        check("fix_latency", 32'(lat), 32'(LAT));
        check("fix_valid", 32'(bus.digit_valid), 32'b1111);
        check("bad_sticky", 32'(bus.bad_pattern), 32'd1);
        bus.clear_error = 1'b1;
        wait_edges(1);
        bus.clear_error = 1'b0;
        check("bad_cleared", 32'(bus.bad_pattern), 32'd0);

        // Blank pattern invalidates digit 2 without touching value
        drive(4'b0100, 7'b1110000); exp_q.push_back(16'hA780); hold(30, lat);
        upd0 = n_upd;
        drive(4'b0100, 7'b0000000); hold(30, lat);
        check("blank_valid", 32'(bus.digit_valid), 32'b1011);
        check("blank_value", 32'(bus.value[11:8]), 32'h7);
        check("blank_no_update", 32'(n_upd - upd0), 32'd0);
        check("blank_no_error", 32'(bus.bad_pattern), 32'd0);

        // Multi-hot select is a blanking interval
        drive(4'b0110, 7'b1111110); hold(30, lat);
        check("multihot_value", 32'(bus.value), 32'hA780);
        check("multihot_valid", 32'(bus.digit_valid), 32'b1011);
        check("multihot_no_update", 32'(n_upd - upd0), 32'd0);

        // Reset mid-stability, then capture restarts from scratch
        drive(4'b0001, 7'b1001111);
        wait_edges(11);
        reset = 1'b1;
        wait_edges(1);
        check("midrst_value", 32'(bus.value), 32'h0);
        check("midrst_valid", 32'(bus.digit_valid), 32'h0);
        check("midrst_update", 32'(bus.update), 32'd0);
        check("midrst_bad", 32'(bus.bad_pattern), 32'd0);
        reset = 1'b0;
        exp_q.push_back(16'h000E);
        hold(40, lat);
        check("post_rst_latency", 32'(lat), 32'(LAT));
        check("post_rst_value", 32'(bus.value), 32'h000E);
        check("post_rst_valid", 32'(bus.digit_valid), 32'b0001);

        wait_edges(2);
        check("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/seg7_capture.md
Name: seg7_capture

Overview:
- Receiver side of the 7-segment display interface: samples segment lines abcdefg plus digit-select lines driven by an external display driver, e.g. another board's multiplexed display on pio.
- Decodes each stable segment pattern back to a hex nibble and stores it per digit.
- Used to read a display-driving board's output back into logic, such as a loopback check of the add-and-display path.
- Sits directly behind the pio pins and feeds the local datapath.

Parameters:
DIGITS, 4, number of multiplexed digit positions captured
STABLE_CYCLES, 16, consecutive synchronized cycles a sample must stay unchanged before capture (>=2)

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
abcdefg_in  input  7  segment lines, bit6=a … bit0=g, 1=segment lit, asynchronous to clk
digit_in  input  DIGITS  digit-select lines, one-hot when a digit is shown, asynchronous to clk
clear_error  input  1  clears bad_pattern
value  output  4*DIGITS  captured nibbles, digit i at [4i+3:4i]
digit_valid  output  DIGITS  digit i holds a valid decoded nibble
update  output  1  one-cycle pulse when any nibble is written
bad_pattern  output  1  sticky: an undecodable pattern was seen on a selected digit

Behaviour:
- Reset: all of the following are 0 on the first edge with reset high: value, digit_valid, update, bad_pattern, synchronizer flops, previous-sample register, stability counter. Reset mid-capture discards any partial stability count.
- Synchronizer: two flops on the concatenated bus {digit_in, abcdefg_in}; the second-stage output is the sample s.
- Stability:
  - Register s_prev <= s every cycle.
  - If s != s_prev, cnt <= 0; else cnt increments, saturating at STABLE_CYCLES.
  - Capture fires on the cycle where s == s_prev and cnt == STABLE_CYCLES-1, so exactly once per stable period.
- Latency: update is high in the cycle after rising edge STABLE_CYCLES+3, counting the first edge after the pin change as edge 1. For the default this is edge 19.
- Decode table (pattern -> nibble):
  - 1111110->0, 0110000->1, 1101101->2, 1111001->3
  - 0110011->4, 1011011->5, 1011111->6, 1110000->7
  - 1111111->8, 1111011->9, 1110111->A, 0011111->b
  - 1001110->C, 0111101->d, 1001111->E, 1000111->F
- On capture, let sel = synced digit field:
  - sel not one-hot (zero or several bits): blanking interval; no state change, no error.
  - sel one-hot at index i, pattern in table: value nibble i <= decoded; digit_valid[i] <= 1; update <= 1 for one cycle. update pulses even if the same nibble is rewritten.
  - sel one-hot, pattern 0000000 (blank): digit_valid[i] <= 0; value nibble i unchanged; no update, no error.
  - sel one-hot, any other pattern: bad_pattern <= 1; digit_valid[i] <= 0; value nibble unchanged; no update.
- Other digits are never disturbed by a capture on digit i.
- update is 0 on every cycle other than the one following a valid capture.
- clear_error:
  - bad_pattern <= 0 on the next edge.
  - If an error capture occurs on the same edge, set wins and bad_pattern stays 1.
- Multiplex rate: each digit must be held for at least STABLE_CYCLES+2 clk cycles to be captured. Shorter holds are ignored silently.

Test Plan:
- Reset then idle inputs 0 for 50 cycles -> value=0, digit_valid=0, update never high, bad_pattern=0.
- digit_in=0001, abcdefg_in=1111001 held 30 cycles -> single update pulse in the cycle after edge 19; value[3:0]=3, digit_valid=0001.
- Rotate digits 0..3 showing 0, C, 5, A with 40 cycles each and 5 cycles of digit_in=0 between -> value=16'hA5C0, digit_valid=1111, exactly 4 update pulses. A 10-cycle glitch pattern 1111111 on digit 2 inserted afterwards -> no change.
- digit 1 at 1111111, then digit 1 at 1010101 held 30 cycles -> value[7:4]=8, digit_valid[1] 1->0, bad_pattern=1 and stays 1. Pulsing clear_error while the same invalid pattern re-captures -> bad_pattern stays 1; clear_error after the pattern is fixed -> bad_pattern=0.
- digit 2 valid (7), then blank 0000000 held 30 cycles -> digit_valid[2]=0, value[11:8]=7, no update, no error. digit_in=0110 with 1111110 -> no change.
- Assert reset for 1 cycle mid-stability (cnt≈8) -> all outputs 0 the next cycle. With inputs still held, capture completes a full STABLE_CYCLES+3 edges after reset deasserts.
